// File: rtl/mpb_arbiter_pkg.sv
// Shared types, constants and helpers for the MPB arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mpb_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Read data returned on a timed-out transfer; sliced down to DATA_W (max 64).
  localparam logic [63:0] MPB_ERR_RDATA = '1;

  // Index width that never collapses to zero bits (N=1 or N=2 still get 1 bit).
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mpb_arb_rr_pick.sv
// Round-robin picker: first asserted request searching upward from rr_ptr+1.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the caller decides when the pick is consumed.
module mpb_arb_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    rr_ptr,
  output logic             any,
  output logic [IW-1:0]    idx
);

  logic [IW-1:0] cand;

  // Scan farthest-first so the nearest requester after rr_ptr is written last and wins.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      cand = IW'((int'(rr_ptr) + i) % N_REQ);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/mpb_arbiter.sv
// Shares one MPB target between N_REQ requesters with round-robin grants and optional timeout.
// Latency: 1 arbitration cycle, then target path is combinational; 1 idle bubble between grants.
// Backpressure: requesters hold vld until req_rdy; target stalls via tgt_rdy, bounded by TIMEOUT.
module mpb_arbiter
  import mpb_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [N_REQ-1:0]               req_vld,
  input  logic [N_REQ-1:0]               req_wr,
  input  logic [N_REQ*ADDR_W-1:0]        req_addr,
  input  logic [N_REQ*DATA_W-1:0]        req_wdata,
  output logic [N_REQ-1:0]               req_rdy,
  output logic [DATA_W-1:0]              req_rdata,
  output logic                           req_err,
  output logic                           tgt_vld,
  output logic                           tgt_wr,
  output logic [ADDR_W-1:0]              tgt_addr,
  output logic [DATA_W-1:0]              tgt_wdata,
  input  logic                           tgt_rdy,
  input  logic [DATA_W-1:0]              tgt_rdata,
  output logic [clog2_min1(N_REQ)-1:0]   gnt_id,
  output logic                           busy
);

  localparam int IW     = clog2_min1(N_REQ);
  localparam int CW     = clog2_min1(TIMEOUT + 1);
  localparam bit TMO_EN = (TIMEOUT > 0);

  state_t        state_q, state_d;
  logic [IW-1:0] gnt_q, gnt_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pick_any;
  logic [IW-1:0] pick_idx;
  logic          active;
  logic          sel_vld;
  logic          done;
  logic          tmo_hit;

  mpb_arb_rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req    (req_vld),
    .rr_ptr (rr_q),
    .any    (pick_any),
    .idx    (pick_idx)
  );

  // Qualifiers for the granted transfer; outputs are forced quiet while reset is held.
  always_comb begin
    active  = reset_n && (state_q == BUSY);
    sel_vld = req_vld[gnt_q];
    done    = active && sel_vld && tgt_rdy;
    tmo_hit = TMO_EN && active && sel_vld && !tgt_rdy && (cnt_q == CW'(TIMEOUT - 1));
  end

  // State register with synchronous reset; rr_ptr starts at the top so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_q    <= IW'(N_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: grant in IDLE, release on completion/timeout, drop silently on abandon.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pick_any) begin
          state_d = BUSY;
          gnt_d   = pick_idx;
        end
      end
      BUSY: begin
        if (done || tmo_hit) begin
          state_d = IDLE;
          rr_d    = gnt_q;
        end else if (!sel_vld) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output muxes: route granted requester to the target and the completion back to it.
  always_comb begin
    tgt_vld   = 1'b0;
    tgt_wr    = 1'b0;
    tgt_addr  = '0;
    tgt_wdata = '0;
    req_rdy   = '0;
    req_rdata = '0;
    req_err   = 1'b0;
    if (active) begin
      tgt_vld   = sel_vld && !tmo_hit;
      tgt_wr    = req_wr[gnt_q];
      tgt_addr  = req_addr[int'(gnt_q)*ADDR_W +: ADDR_W];
      tgt_wdata = req_wdata[int'(gnt_q)*DATA_W +: DATA_W];
      req_rdata = tmo_hit ? MPB_ERR_RDATA[DATA_W-1:0] : tgt_rdata;
      req_err   = tmo_hit;
      if (done || tmo_hit) begin
        req_rdy[gnt_q] = 1'b1;
      end
    end
  end

  assign gnt_id = gnt_q;
  assign busy   = active;

endmodule

// File: doc/mpb_arbiter.md
Name: mpb_arbiter

Overview:
- Shares one Matrix Peripheral Bus (MPB) target between N_REQ MPB requesters.
- Round-robin arbitration; a grant is held until the granted transfer completes, i.e. vld and rdy are both high on the target side.
- Optional completion timeout terminates a transfer the target never acknowledges.
- Sits between requester masters and a single MPB slave; the self-test bench drives it as a DUT.

Parameters:
- N_REQ, 4, number of requester ports (2..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 256, cycles of BUSY without tgt_rdy before forced termination; 0 disables the timeout

Ports:
- clk  in  1  single clock, all logic rising-edge
- reset_n  in  1  synchronous active-low reset
- req_vld  in  N_REQ  per-requester transfer valid
- req_wr  in  N_REQ  per-requester write(1)/read(0)
- req_addr  in  N_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  N_REQ*DATA_W  packed write data, same packing
- req_rdy  out  N_REQ  per-requester completion strobe
- req_rdata  out  DATA_W  shared read data, qualified by req_rdy[i]
- req_err  out  1  high with req_rdy when the transfer was terminated by timeout
- tgt_vld  out  1  target valid
- tgt_wr  out  1  target write/read
- tgt_addr  out  ADDR_W  target address
- tgt_wdata  out  DATA_W  target write data
- tgt_rdy  in  1  target ready/complete
- tgt_rdata  in  DATA_W  target read data
- gnt_id  out  $clog2(N_REQ)  currently granted requester (valid when busy)
- busy  out  1  state == BUSY

Behaviour:
- MPB handshake: master holds vld, wr, addr and wdata stable until the cycle where vld and rdy are both high. That cycle completes the transfer, and rdata is valid in it.
- Interface decision: one clock `clk`; reset `reset_n` is synchronous and active-low.
- Reset (reset_n == 0 at a clk edge), registered state:
  - state = IDLE
  - gnt_id = 0
  - rr_ptr = N_REQ-1, so requester 0 wins first
  - timeout counter = 0
- Outputs while in reset or IDLE:
  - tgt_vld = 0, req_rdy = 0, req_err = 0, busy = 0
  - tgt_wr = 0, tgt_addr = 0, tgt_wdata = 0
  - req_rdata = 0
- FSM states: IDLE, BUSY.
- IDLE:
  - If any req_vld is high, pick the first asserted requester searching from rr_ptr+1 upward, modulo N_REQ.
  - Register the pick into gnt_id and go to BUSY at the next edge.
  - Arbitration costs exactly 1 cycle.
- BUSY, target mux (combinational from gnt_id):
  - tgt_vld = req_vld[gnt_id]
  - tgt_wr, tgt_addr, tgt_wdata taken from requester gnt_id
- BUSY, completion:
  - req_rdy[gnt_id] = tgt_rdy & tgt_vld, combinational and same-cycle; all other req_rdy bits are 0.
  - req_rdata = tgt_rdata.
  - At completion: rr_ptr <= gnt_id, state <= IDLE.
  - One bubble cycle always separates consecutive grants. Minimum transfer-to-transfer spacing is 2 cycles when tgt_rdy is combinational.
- BUSY, abandon: if req_vld[gnt_id] drops without completion (protocol violation), go to IDLE. rr_ptr is unchanged and no req_rdy is issued.
- Timeout (TIMEOUT > 0):
  - Counter clears on entering BUSY and increments each BUSY cycle without completion.
  - When the counter equals TIMEOUT-1 and tgt_rdy is low, that cycle drives req_rdy[gnt_id] = 1, req_err = 1, req_rdata = all ones, and tgt_vld = 0.
  - Next state is IDLE with rr_ptr <= gnt_id.
  - If tgt_rdy is high in the same cycle, normal completion wins and req_err = 0.
- Requests arriving during BUSY are held by the requesters and considered at the next IDLE; no queueing.
- Reset asserted mid-BUSY: the transfer is dropped immediately at that edge, with no req_rdy and no req_err.
- gnt_id stays registered, and holds its last value in IDLE.

Decomposition:
- Package mpb_arbiter_pkg:
  - state enum {IDLE, BUSY}
  - MPB_ERR_RDATA constant (all ones)
  - function clog2_min1 for gnt_id width
- Sub-module mpb_arb_rr_pick: purely combinational round-robin picker.
  - Inputs: request vector, rr_ptr.
  - Outputs: any, index.
  - Instantiated once.
- The top module holds the FSM, timeout counter and muxes.

Test Plan:
1. Single write: req0 vld, wr=1, addr=0x10, wdata=0xA5A5_0001; target rdy 2 cycles after tgt_vld rises -> tgt_vld high 1 cycle after req_vld; tgt_addr = 0x10; req_rdy[0] pulses 1 cycle coincident with tgt_rdy; req_err = 0.
2. Fairness: req0..req3 all hold vld continuously with rdy immediate -> grants in order 0,1,2,3,0; each grant separated by exactly 2 cycles.
3. Read data: req2 read addr=0x24 with tgt_rdata = 0x1234_5678 at rdy -> req_rdata = 0x1234_5678 with req_rdy[2]; req_rdy[0,1,3] = 0.
4. Timeout (TIMEOUT = 8): tgt_rdy tied 0 -> in the 8th BUSY cycle, req_rdy[g] = 1, req_err = 1, req_rdata = 0xFFFF_FFFF, tgt_vld = 0; next grant goes to the following requester.
5. Reset mid-transfer: req1 granted, reset_n low for 1 cycle before rdy -> outputs 0 next cycle; no req_rdy[1]; after release, req0 wins over simultaneous req1.
6. Timeout/rdy coincidence: tgt_rdy rises exactly at count TIMEOUT-1 -> normal completion, req_err = 0, req_rdata = tgt_rdata.
